sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_pkg.sv | 27 ++
 rtl/sram_arbiter_pick.sv | 24 ++
 rtl/sram_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam int GNT_INST = 0;
  localparam int GNT_DATA = 1;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } slot_t;

  // Last grant is treated as inst after reset so that data wins the first conflict.
  localparam owner_e PTR_RST = OWN_INST;

  function automatic owner_e gnt_owner(input logic [1:0] gnt);
    return gnt[GNT_DATA] ? OWN_DATA : OWN_INST;
  endfunction

endpackage

// File: rtl/sram_arbiter_pick.sv
// arb_pick_2: grant decision between the inst and data requesters.
module arb_pick_2
  import sram_arbiter_pkg::*;
(
  input  logic       req_inst_i,
  input  logic       req_data_i,
  input  owner_e     last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    if (req_inst_i && req_data_i) begin
      // On conflict the side that did not win last time takes this cycle.
      if (last_i == OWN_DATA) gnt_o[GNT_INST] = 1'b1;
      else                    gnt_o[GNT_DATA] = 1'b1;
    end else if (req_data_i) begin
      gnt_o[GNT_DATA] = 1'b1;
    end else if (req_inst_i) begin
      gnt_o[GNT_INST] = 1'b1;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM between instruction fetch and load/store ports.
// Define ARB_RR_EN for round-robin conflict resolution; otherwise data always wins.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_rdy,
  output logic              inst_rvalid,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_rdy,
  output logic              data_rvalid,
  output logic [DATA_W-1:0] data_rdata,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  logic                     inst_req_v;
  logic                     data_req_v;
  logic [1:0]               gnt;
  logic                     accept;
  logic                     rd_accept;
  owner_e                   acc_owner;
  owner_e                   last_own;
  slot_t [RD_LAT-1:0]       pipe_q;
  slot_t [RD_LAT-1:0]       pipe_d;
  slot_t                    head;

  // Requests are masked while in reset so rdy and sram_en drop immediately.
  assign inst_req_v = inst_req & resetn;
  assign data_req_v = data_req & resetn;

  arb_pick_2 u_pick (
    .req_inst_i (inst_req_v),
    .req_data_i (data_req_v),
    .last_i     (last_own),
    .gnt_o      (gnt)
  );

  assign inst_rdy  = gnt[GNT_INST];
  assign data_rdy  = gnt[GNT_DATA];
  assign accept    = |gnt;
  assign acc_owner = gnt_owner(gnt);
  assign rd_accept = accept & ~(gnt[GNT_DATA] & data_we);

`ifdef ARB_RR_EN
  owner_e last_q;
  owner_e last_d;

  always_comb begin
    last_d = last_q;
    if (accept) last_d = acc_owner;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) last_q <= PTR_RST;
    else         last_q <= last_d;
  end

  assign last_own = last_q;
`else
  assign last_own = PTR_RST;
`endif

  assign sram_en    = accept;
  assign sram_we    = gnt[GNT_DATA] & data_we;
  assign sram_addr  = gnt[GNT_DATA] ? data_addr : inst_addr;
  assign sram_wdata = data_wdata;

  always_comb begin
    pipe_d          = pipe_q;
    pipe_d[0].valid = rd_accept;
    pipe_d[0].owner = acc_owner;
    for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];
  end

  // Clearing the owner pipeline drops any read that was in flight at reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) pipe_q <= '0;
    else         pipe_q <= pipe_d;
  end

  assign head        = pipe_q[RD_LAT-1];
  assign inst_rvalid = head.valid & (head.owner == OWN_INST);
  assign data_rvalid = head.valid & (head.owner == OWN_DATA);
  assign inst_rdata  = sram_rdata;
  assign data_rdata  = sram_rdata;

endmodule
